// File: rtl/glove_pkg.sv
// glove_pkg: shared constants and types for the glove word builder.
//   CHAR_W / MAX_LEN / WORD_W : character width, word capacity, packed word width
//   CODE_*                    : special classifier codes
//   word_t, code_t            : packed word and character types
//   wb_state_t                : word builder FSM states
package glove_pkg;

    localparam int CHAR_W  = 5;
    localparam int MAX_LEN = 24;
    localparam int WORD_W  = CHAR_W * MAX_LEN;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CHAR_W-1:0] code_t;

    localparam code_t CODE_BLANK = 5'd0;
    localparam code_t CODE_Z     = 5'd26;
    localparam code_t CODE_END   = 5'd27;
    localparam code_t CODE_DEL   = 5'd28;

    typedef enum logic [1:0] {
        COLLECT,
        LAUNCH,
        WAIT,
        DONE
    } wb_state_t;

    // Letters are 'a'..'z' mapped to 1..26.
    function automatic logic is_letter(code_t code);
        return (code != CODE_BLANK) && (code <= CODE_Z);
    endfunction

endpackage

// File: rtl/word_builder_if.sv
// word_builder_if: classifier input, Dictionary handshake and word output.
//   i_valid/i_code            : classifier sample strobe and code
//   i_dict_finish/i_dict_word : Dictionary done level and corrected word
//   o_dict_start/o_dict_word  : Dictionary start pulse and raw packed word
//   o_word/o_word_valid       : corrected word and its update pulse
//   o_len/o_busy              : letter count and busy flag
// Modport slave is the word builder; master is whoever drives it.
interface word_builder_if;
    import glove_pkg::*;

    logic       i_valid;
    code_t      i_code;
    logic       i_dict_finish;
    word_t      i_dict_word;
    logic       o_dict_start;
    word_t      o_dict_word;
    word_t      o_word;
    logic       o_word_valid;
    logic [4:0] o_len;
    logic       o_busy;

    modport slave (
        input  i_valid, i_code, i_dict_finish, i_dict_word,
        output o_dict_start, o_dict_word, o_word, o_word_valid, o_len, o_busy
    );

    modport master (
        output i_valid, i_code, i_dict_finish, i_dict_word,
        input  o_dict_start, o_dict_word, o_word, o_word_valid, o_len, o_busy
    );

endinterface

// File: rtl/gesture_debounce.sv
// gesture_debounce: accepts a classifier symbol once it has been seen on
// HOLD_FRAMES consecutive valid samples, and only once per gesture (a blank
// sample re-arms it).
//   i_clk, i_rst_n : clock, async active-low reset
//   i_valid/i_code : classifier sample
//   i_enable       : samples are only considered while high
//   i_clear        : synchronous clear of all state, leaves it disarmed
//   o_accept/o_sym : one-cycle accept strobe and the accepted symbol
module gesture_debounce
    import glove_pkg::*;
#(
    parameter int HOLD_FRAMES = 8
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_valid,
    input  code_t i_code,
    input  logic  i_enable,
    input  logic  i_clear,
    output logic  o_accept,
    output code_t o_sym
);

    localparam logic [7:0] HOLD = 8'(HOLD_FRAMES);

    code_t      cand_q;
    logic [7:0] run_q;
    logic       armed_q;
    logic [7:0] run_next;
    logic       sample_hit;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        run_next   = 8'd1;
        sample_hit = i_enable && i_valid && (i_code != CODE_BLANK);
        if (i_code == cand_q) begin
            run_next = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        end
    end

    // Accepted on the very sample that completes the run, so the caller acts at the next edge.
    assign o_accept = sample_hit && armed_q && (run_next == HOLD);
    assign o_sym    = i_code;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cand_q  <= CODE_BLANK;
            run_q   <= 8'd0;
            armed_q <= 1'b1;
        end else if (i_clear) begin
            cand_q  <= CODE_BLANK;
            run_q   <= 8'd0;
            armed_q <= 1'b0;
        end else if (i_enable && i_valid) begin
            if (i_code != CODE_BLANK) begin
                cand_q <= i_code;
                run_q  <= run_next;
                if (o_accept) begin
                    armed_q <= 1'b0;
                end
            end else begin
                run_q   <= 8'd0;
                armed_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/word_builder.sv
// word_builder: assembles debounced glove letters into a packed word, hands
// it to Dictionary on END and presents the corrected word.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : word_builder_if slave (classifier, Dictionary, output)
// Letter k sits at bits [5k+4:5k]; unused slots read as zero.
module word_builder
    import glove_pkg::*;
#(
    parameter int CHAR_W      = glove_pkg::CHAR_W,
    parameter int MAX_LEN     = glove_pkg::MAX_LEN,
    parameter int HOLD_FRAMES = 8
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    word_builder_if.slave  bus
);

    wb_state_t  state_q, state_d;
    word_t      buffer_q;
    word_t      word_q;
    logic [4:0] len_q;
    logic [4:0] last_idx;
    logic       accept;
    code_t      sym;
    logic       collecting;
    logic       finishing;
    logic       dict_start;
    logic       word_valid;
    logic       busy;

    assign collecting = (state_q == COLLECT);
    assign finishing  = (state_q == WAIT) && bus.i_dict_finish;
    assign last_idx   = len_q - 5'd1;

    gesture_debounce #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_debounce (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (bus.i_valid),
        .i_code   (bus.i_code),
        .i_enable (collecting),
        .i_clear  (state_q == DONE),
        .o_accept (accept),
        .o_sym    (sym)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dict_start = 1'b0;
        word_valid = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            COLLECT: begin
                busy = 1'b0;
                if (accept && (sym == CODE_END) && (len_q != 5'd0)) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                dict_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (bus.i_dict_finish) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                word_valid = 1'b1;
                state_d    = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // The corrected word is captured on the finishing edge so it is already
    // visible during DONE, alongside the valid pulse. The raw buffer only
    // changes in COLLECT, which keeps it stable for Dictionary.
    // NOTE: the buffer is a plain register (not RAM), so it is reset: every output must read zero out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buffer_q <= '0;
            len_q    <= 5'd0;
            word_q   <= '0;
        end else if (finishing) begin
            word_q   <= bus.i_dict_word;
            buffer_q <= '0;
            len_q    <= 5'd0;
        end else if (collecting && accept) begin
            if (is_letter(sym) && (len_q < 5'(MAX_LEN))) begin
                buffer_q[CHAR_W*int'(len_q) +: CHAR_W] <= sym;
                len_q                                  <= len_q + 5'd1;
            end else if ((sym == CODE_DEL) && (len_q != 5'd0)) begin
                buffer_q[CHAR_W*int'(last_idx) +: CHAR_W] <= '0;
                len_q                                     <= last_idx;
            end
        end
    end

    assign bus.o_dict_start = dict_start;
    assign bus.o_dict_word  = buffer_q;
    assign bus.o_word       = word_q;
    assign bus.o_word_valid = word_valid;
    assign bus.o_len        = len_q;
    assign bus.o_busy       = busy;

endmodule

// File: doc/word_builder.md
# word_builder

Collects the per-frame letter classifications from the glove gesture classifier and assembles them into a packed 120-bit word. Each letter is debounced over several consecutive frames, and delete and end-of-word gestures are supported. On end-of-word it launches `Dictionary` with a one-cycle start pulse and waits for its finish. It then presents the corrected word downstream with a one-cycle valid pulse.

## Interface
Parameters:
- `CHAR_W`, 5 — bits per character code
- `MAX_LEN`, 24 — maximum letters per word; `CHAR_W*MAX_LEN` = 120
- `HOLD_FRAMES`, 8 — consecutive matching valid samples required to accept a symbol (range 1..255)

Ports:
- `i_clk` — in, 1 — clock
- `i_rst_n` — in, 1 — reset, asynchronous, active-low
- `i_valid` — in, 1 — classifier sample strobe
- `i_code` — in, 5 — 0 blank, 1..26 = 'a'..'z', 27 END, 28 DELETE, 29..31 ignored
- `i_dict_finish` — in, 1 — `Dictionary` done (level, sampled only in WAIT)
- `i_dict_word` — in, 120 — `Dictionary` corrected word
- `o_dict_start` — out, 1 — one-cycle start pulse to `Dictionary`
- `o_dict_word` — out, 120 — raw packed word to `Dictionary`
- `o_word` — out, 120 — last corrected word, held until the next DONE
- `o_word_valid` — out, 1 — one-cycle pulse when `o_word` updates
- `o_len` — out, 5 — current letter count (0..24)
- `o_busy` — out, 1 — high in LAUNCH/WAIT/DONE

## Operation
- **Packing**
  - Letter k (0 = first typed) occupies bits [5k+4:5k].
  - Unused slots are 0.
  - `o_dict_word` is the live buffer.
- **Debounce** (active only in COLLECT)
  - Registers: candidate code, run counter (8 bit, saturating), `armed` flag.
  - On a valid sample with nonzero code:
    - code equal to the candidate → run++;
    - otherwise → candidate = code and run = 1.
  - On a valid sample with code 0 → run = 0 and `armed` = 1.
  - Samples with `i_valid` low leave all debounce state unchanged.
  - A symbol is accepted when run reaches `HOLD_FRAMES` and `armed` = 1. Acceptance clears `armed`, so the same gesture held longer is never accepted twice.
- **Accepted symbol actions**
  - Letter with len < 24 → write the slot at index len, len++.
  - Letter with len = 24 → dropped.
  - DELETE with len > 0 → zero slot len−1, len--.
  - DELETE on an empty buffer → no-op.
  - END with len > 0 → go to LAUNCH.
  - END on an empty buffer → no-op.
  - Codes 29..31 → no-op (`armed` is still cleared).
- **FSM** states COLLECT, LAUNCH, WAIT, DONE:
  - COLLECT→LAUNCH on accepted END.
  - LAUNCH: `o_dict_start` = 1 for exactly one cycle → WAIT.
  - WAIT→DONE when `i_dict_finish` = 1; otherwise stay.
  - DONE: `o_word` ← `i_dict_word`, `o_word_valid` = 1, buffer and len cleared, debounce state cleared, `armed` = 0 → COLLECT.
- Classifier input outside COLLECT is ignored.
- `o_dict_word` is stable from LAUNCH through WAIT.

## Timing
- **Reset values**: every output 0; state COLLECT; buffer, len, candidate and run 0; `armed` = 1.
- **Reset mid-operation**: reset asserted in any state returns to these values immediately (asynchronously). No start pulse or valid pulse follows.
- **Letter latency**: accepted on the cycle of the `HOLD_FRAMES`-th matching sample; buffer and `o_len` update at the next edge.
- **END latency**: END accepted in cycle t → `o_dict_start` high in cycle t+1 only; WAIT from t+2.
- **Finish latency**: `i_dict_finish` seen high in cycle f (state WAIT) → `o_word`/`o_word_valid` in f+1; COLLECT from f+2.
- `i_dict_finish` already high on the first WAIT cycle is accepted; `Dictionary` holding finish high is harmless.
- Back-to-back valid samples every cycle are supported.

## Structure
- Package `glove_pkg`:
  - `CHAR_W`, `MAX_LEN`, `WORD_W` = 120;
  - `CODE_BLANK` = 0, `CODE_END` = 27, `CODE_DEL` = 28;
  - typedef `word_t` = logic [119:0];
  - enum `wb_state_t` {COLLECT, LAUNCH, WAIT, DONE}.
- One sub-module `gesture_debounce`:
  - inputs: `i_valid`, `i_code`, enable, clear;
  - outputs: one-cycle `o_accept` and `o_sym`.
- `word_builder` holds the buffer, len and FSM, and instantiates `Dictionary` nowhere (it is wired at top level).

## Test plan
- **Single letter + END**: 8 samples of code 16, 1 blank, 8 samples of 27 → `o_dict_start` pulses once with `o_dict_word` = 120'h10, `o_len` = 1.
- **Debounce and re-arm**:
  - 7 samples of 3 then 8 of 4 → only 'd' (4) stored;
  - 20 more samples of 4 with no blank → len stays 1;
  - blank then 8 samples of 4 → len 2, bits [9:5] = 4.
- **DELETE**: type 1,2,3, then DELETE → len 2 and bits [14:10] = 0. DELETE ×3 → len 0, no underflow.
- **Full and empty boundaries**:
  - 25 letters → len 24, 25th dropped;
  - END on an empty buffer → no start pulse.
- **Handshake**: model asserts `i_dict_finish` 50 cycles after start with word X → `o_word` = X, one-cycle `o_word_valid`, len 0; letters during WAIT are ignored.
- **Reset in WAIT**: drop `i_rst_n` mid-WAIT → all outputs 0 asynchronously; a later finish produces no `o_word_valid`.
